// File: rtl/gzip_sim_pkg.sv
// Shared constants, CRC32 byte step and FSM state type for the stream sink checker.
package gzip_sim_pkg;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        REPORT
    } state_e;

    // Reflected CRC32 update for one byte, eight unrolled bit steps.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_stream_sink_checker_if.sv
// Byte-wide AXI-stream input plus per-stream result handshake.
interface axis_stream_sink_checker_if;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;
    logic        tlast;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_length;
    logic [31:0] o_crc;
    logic        o_short;
    logic [15:0] o_stream_cnt;

    // Stream source / result consumer side.
    modport master (
        output tvalid, tdata, tlast, o_ready,
        input  tready, o_valid, o_length, o_crc, o_short, o_stream_cnt
    );

    // Checker side.
    modport slave (
        input  tvalid, tdata, tlast, o_ready,
        output tready, o_valid, o_length, o_crc, o_short, o_stream_cnt
    );
endinterface

// File: rtl/lfsr_stall_gen.sv
// Free-running 16-bit Galois LFSR producing a pseudo-random stall request.
module lfsr_stall_gen
    import gzip_sim_pkg::*;
#(
    parameter int unsigned STALL_THRESH = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rstn,
    output logic stall
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Galois right-shift step.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    // LFSR advances every cycle once out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= SeedEff;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    if (STALL_THRESH == 0) begin : g_no_stall
        assign stall = 1'b0;
    end else begin : g_stall
        assign stall = ({24'd0, lfsr_q[7:0]} < STALL_THRESH);
    end

endmodule

// File: rtl/axis_stream_sink_checker.sv
// AXI-stream byte sink: per-stream length, gzip CRC32 and short flag, with random backpressure.
module axis_stream_sink_checker
    import gzip_sim_pkg::*;
#(
    parameter int unsigned MIN_LEN      = 32,
    parameter int unsigned STALL_THRESH = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic                       clk,
    input logic                       rstn,
    axis_stream_sink_checker_if.slave bus
);

    logic        stall;
    logic        beat;
    logic        last_beat;
    logic        handshake;
    state_e      state_q, state_d;
    logic        tready_q, tready_d;
    logic        o_valid_q;
    logic [31:0] o_length_q;
    logic [31:0] o_crc_q;
    logic        o_short_q;
    logic [15:0] cnt_q;
    logic [31:0] len_acc_q;
    logic [31:0] crc_acc_q;
    logic [31:0] len_next;
    logic [31:0] crc_next;

    lfsr_stall_gen #(
        .STALL_THRESH (STALL_THRESH),
        .LFSR_SEED    (LFSR_SEED)
    ) u_stall (
        .clk   (clk),
        .rstn  (rstn),
        .stall (stall)
    );

    assign beat      = bus.tvalid & tready_q;
    assign last_beat = beat & bus.tlast;
    assign handshake = o_valid_q & bus.o_ready;
    assign len_next  = len_acc_q + 32'd1;
    assign crc_next  = crc32_byte(crc_acc_q, bus.tdata);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a tlast beat always lands in REPORT, even from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (beat) state_d = bus.tlast ? REPORT : RECV;
            RECV:    if (last_beat) state_d = REPORT;
            REPORT:  if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: ready drops after a tlast beat and stays low while a result is pending.
    always_comb begin
        tready_d = ~stall & ~last_beat & ~(o_valid_q & ~bus.o_ready)
                 & ((state_q != REPORT) | bus.o_ready);
    end

    // Registered ready, accumulators and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tready_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_length_q <= 32'd0;
            o_crc_q    <= 32'd0;
            o_short_q  <= 1'b0;
            cnt_q      <= 16'd0;
            len_acc_q  <= 32'd0;
            crc_acc_q  <= CRC32_INIT;
        end else begin
            tready_q <= tready_d;
            if (handshake) begin
                o_valid_q <= 1'b0;
                cnt_q     <= cnt_q + 16'd1;
            end
            if (beat) begin
                if (bus.tlast) begin
                    o_valid_q  <= 1'b1;
                    o_length_q <= len_next;
                    o_crc_q    <= ~crc_next;
                    o_short_q  <= (len_next < MIN_LEN);
                    len_acc_q  <= 32'd0;
                    crc_acc_q  <= CRC32_INIT;
                end else begin
                    len_acc_q <= len_next;
                    crc_acc_q <= crc_next;
                end
            end
        end
    end

    assign bus.tready       = tready_q;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_length     = o_length_q;
    assign bus.o_crc        = o_crc_q;
    assign bus.o_short      = o_short_q;
    assign bus.o_stream_cnt = cnt_q;

endmodule

// File: tb/tb_axis_stream_sink_checker.sv
// Randomized self-checking bench for axis_stream_sink_checker with a table-driven CRC model.
module tb_axis_stream_sink_checker;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel = 1'b0;
    logic        src_tvalid = 1'b0;
    logic [7:0]  src_tdata = 8'd0;
    logic        src_tlast = 1'b0;
    logic        src_o_ready = 1'b1;

    logic        cur_tready, cur_o_valid, cur_o_short;
    logic [31:0] cur_o_length, cur_o_crc;
    logic [15:0] cur_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] crc_tab [256];
    logic [31:0] exp_crc;
    logic [31:0] exp_len;
    int          mon_en = 0;
    int          mon_cyc = 0;
    int          mon_low = 0;

    axis_stream_sink_checker_if u_if0 ();
    axis_stream_sink_checker_if u_if1 ();

    assign u_if0.tvalid  = ~sel & src_tvalid;
    assign u_if0.tdata   = src_tdata;
    assign u_if0.tlast   = src_tlast;
    assign u_if0.o_ready = sel ? 1'b1 : src_o_ready;
    assign u_if1.tvalid  = sel & src_tvalid;
    assign u_if1.tdata   = src_tdata;
    assign u_if1.tlast   = src_tlast;
    assign u_if1.o_ready = sel ? src_o_ready : 1'b1;

    axis_stream_sink_checker #(
        .MIN_LEN      (32),
        .STALL_THRESH (0),
        .LFSR_SEED    (16'hACE1)
    ) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if0)
    );

    axis_stream_sink_checker #(
        .MIN_LEN      (32),
        .STALL_THRESH (128),
        .LFSR_SEED    (16'hACE1)
    ) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if1)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_tready   = sel ? u_if1.tready       : u_if0.tready;
        cur_o_valid  = sel ? u_if1.o_valid      : u_if0.o_valid;
        cur_o_short  = sel ? u_if1.o_short      : u_if0.o_short;
        cur_o_length = sel ? u_if1.o_length     : u_if0.o_length;
        cur_o_crc    = sel ? u_if1.o_crc        : u_if0.o_crc;
        cur_cnt      = sel ? u_if1.o_stream_cnt : u_if0.o_stream_cnt;
    end

    // Backpressure monitor for the stalling instance.
    always @(negedge clk) begin
        if (mon_en != 0) begin
            mon_cyc++;
            if (u_if1.tready !== 1'b1) mon_low++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    function automatic logic [31:0] ref_step(input logic [31:0] crc, input logic [7:0] b);
        logic [7:0] idx;
        idx = crc[7:0] ^ b;
        return (crc >> 8) ^ crc_tab[idx];
    endfunction

    task automatic build_table();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one byte until the checker accepts it; returns at posedge+1 after the beat.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic got;
        int   n;
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = last;
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = cur_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: tready=%0b after %0d cycles, need 1", got, n);
        end
    endtask

    // Send a whole stream and compute its expected length/CRC.
    task automatic send_queue(input logic [7:0] q[$], input bit bubbles);
        exp_crc = 32'hFFFFFFFF;
        exp_len = 32'd0;
        for (int i = 0; i < q.size(); i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                src_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(q[i], i == q.size() - 1);
            exp_crc = ref_step(exp_crc, q[i]);
            exp_len++;
        end
        exp_crc = ~exp_crc;
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rstn = 1'b0;
        #23;
        n_checks++;
        if (cur_tready !== 1'b0 || cur_o_valid !== 1'b0 || cur_o_length !== 32'd0 ||
            cur_o_crc !== 32'd0 || cur_o_short !== 1'b0 || cur_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b v=%0b len=%0d crc=%h sh=%0b cnt=%0d, need all 0",
                     cur_tready, cur_o_valid, cur_o_length, cur_o_crc, cur_o_short, cur_cnt);
        end
        #4 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_check_string();
        logic [7:0] q[$];
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        src_o_ready = 1'b1;
        send_queue(q, 1'b0);
        n_checks++;
        if (cur_o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL str_latency: o_valid=%0b one cycle after tlast, need 1", cur_o_valid);
        end
        n_checks++;
        if (cur_o_length !== 32'd9 || cur_o_crc !== 32'hCBF43926 || cur_o_short !== 1'b1) begin
            n_fail++;
            $display("FAIL str_result: len=%0d crc=%h sh=%0b, need 9 cbf43926 1",
                     cur_o_length, cur_o_crc, cur_o_short);
        end
        n_checks++;
        if (exp_crc !== cur_o_crc) begin
            n_fail++;
            $display("FAIL str_model: crc=%h, model %h", cur_o_crc, exp_crc);
        end
        n_checks++;
        if (cur_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL str_tready_after_last: tready=%0b, need 0", cur_tready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_o_valid !== 1'b0 || cur_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL str_handoff: o_valid=%0b cnt=%0d, need 0 1", cur_o_valid, cur_cnt);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] q[$];
        q.push_back(8'h00);
        send_queue(q, 1'b0);
        n_checks++;
        if (cur_o_valid !== 1'b1 || cur_o_length !== 32'd1 || cur_o_crc !== 32'hD202EF8D ||
            cur_o_short !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte: v=%0b len=%0d crc=%h sh=%0b, need 1 1 d202ef8d 1",
                     cur_o_valid, cur_o_length, cur_o_crc, cur_o_short);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL single_cnt: cnt=%0d, need 2", cur_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  q[$];
        logic [7:0]  q2[$];
        logic [31:0] hold_crc;
        int          bad;
        for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
        src_o_ready = 1'b0;
        send_queue(q, 1'b0);
        hold_crc = exp_crc;
        n_checks++;
        if (cur_o_valid !== 1'b1 || cur_o_length !== 32'd40 || cur_o_short !== 1'b0 ||
            cur_o_crc !== hold_crc) begin
            n_fail++;
            $display("FAIL bp_result: v=%0b len=%0d sh=%0b crc=%h, need 1 40 0 %h",
                     cur_o_valid, cur_o_length, cur_o_short, cur_o_crc, hold_crc);
        end
        // Offer the next stream's first byte while the result is still pending.
        src_tvalid = 1'b1;
        src_tdata  = 8'hA5;
        src_tlast  = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (cur_tready !== 1'b0 || cur_o_valid !== 1'b1 || cur_o_length !== 32'd40 ||
                cur_o_crc !== hold_crc || cur_o_short !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_frozen: cyc %0d rdy=%0b v=%0b len=%0d crc=%h, need 0 1 40 %h",
                             c, cur_tready, cur_o_valid, cur_o_length, cur_o_crc, hold_crc);
            end
            @(posedge clk);
            #1;
        end
        src_o_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_o_valid !== 1'b0 || cur_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_handoff: v=%0b cnt=%0d, need 0 3", cur_o_valid, cur_cnt);
        end
        q2.push_back(8'hA5);
        for (int i = 1; i < 33; i++) q2.push_back(8'($urandom));
        send_queue(q2, 1'b0);
        n_checks++;
        if (cur_o_length !== 32'd33 || cur_o_crc !== exp_crc || cur_o_short !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_stream: len=%0d crc=%h sh=%0b, need 33 %h 0",
                     cur_o_length, cur_o_crc, cur_o_short, exp_crc);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] q[$];
        src_o_ready = 1'b1;
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1'b0);
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (cur_tready !== 1'b0 || cur_o_valid !== 1'b0 || cur_o_length !== 32'd0 ||
            cur_o_crc !== 32'd0 || cur_o_short !== 1'b0 || cur_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_state: rdy=%0b v=%0b len=%0d crc=%h sh=%0b cnt=%0d, need 0",
                     cur_tready, cur_o_valid, cur_o_length, cur_o_crc, cur_o_short, cur_cnt);
        end
        src_tvalid = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        send_queue(q, 1'b0);
        n_checks++;
        if (cur_o_length !== 32'd9 || cur_o_crc !== 32'hCBF43926) begin
            n_fail++;
            $display("FAIL midreset_stream: len=%0d crc=%h, need 9 cbf43926",
                     cur_o_length, cur_o_crc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_cnt: cnt=%0d, need 1", cur_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic       want_short;
        do_reset();
        src_o_ready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            q.delete();
            for (int i = 0; i < 31 + s; i++) q.push_back(8'($urandom));
            send_queue(q, 1'b0);
            want_short = (31 + s) < 32;
            n_checks++;
            if (cur_o_length !== 32'(31 + s) || cur_o_crc !== exp_crc ||
                cur_o_short !== want_short) begin
                n_fail++;
                $display("FAIL b2b_stream%0d: len=%0d crc=%h sh=%0b, need %0d %h %0b",
                         s, cur_o_length, cur_o_crc, cur_o_short, 31 + s, exp_crc, want_short);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_cnt !== 16'd10 || cur_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cnt: cnt=%0d v=%0b, need 10 0", cur_cnt, cur_o_valid);
        end
    endtask

    task automatic test_random_stall();
        logic [7:0] q[$];
        sel = 1'b1;
        src_o_ready = 1'b1;
        for (int i = 0; i < 8000; i++) q.push_back(8'($urandom));
        mon_cyc = 0;
        mon_low = 0;
        mon_en = 1;
        send_queue(q, 1'b1);
        mon_en = 0;
        n_checks++;
        if (cur_o_valid !== 1'b1 || cur_o_length !== exp_len || cur_o_crc !== exp_crc) begin
            n_fail++;
            $display("FAIL stall_stream: v=%0b len=%0d crc=%h, need 1 %0d %h",
                     cur_o_valid, cur_o_length, cur_o_crc, exp_len, exp_crc);
        end
        n_checks++;
        if (mon_low * 100 < mon_cyc * 40 || mon_low * 100 > mon_cyc * 60) begin
            n_fail++;
            $display("FAIL stall_ratio: tready low %0d of %0d cycles, need 40..60 percent",
                     mon_low, mon_cyc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cur_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_cnt: cnt=%0d, need 1", cur_cnt);
        end
        sel = 1'b0;
    endtask

    initial begin
        build_table();
        test_reset();
        test_check_string();
        test_single_byte();
        test_backpressure();
        test_reset_mid_stream();
        test_back_to_back();
        test_random_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
